// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: address field widths,
// queue sizing defaults and the packed entry stored for each fetched word.
package fetch_pkg;

   localparam int OFFSET_SIZE  = 5;
   localparam int INDEX_SIZE   = 8;
   localparam int ADDR_WIDTH   = 64;
   localparam int TAG_SIZE     = ADDR_WIDTH - (OFFSET_SIZE + INDEX_SIZE);
   localparam int INSTR_WIDTH  = 32;
   localparam int DEPTH_LOG2   = 3;
   localparam int SKID_ENTRIES = 2;

   // One queued instruction word together with the address it was fetched from.
   typedef struct packed {
      logic [INSTR_WIDTH-1:0] payload;
      logic [TAG_SIZE-1:0]    tag;
      logic [INDEX_SIZE-1:0]  index;
      logic [OFFSET_SIZE-1:0] offset;
   } fetchEntry_t;

   // Reassembles the full fetch address, tag in the most significant bits.
   function automatic logic [ADDR_WIDTH-1:0] entryAddress(input fetchEntry_t entry);
      return {entry.tag, entry.index, entry.offset};
   endfunction

endpackage

// File: rtl/fifo_storage_ram.sv
// Register-array storage for the fetch queue: one synchronous write port and
// one asynchronous read port so the head entry falls straight through.
module fifo_storage_ram #(
   parameter int dataWidth = 96,
   parameter int addrBits  = 3
) (
   input  logic                 i_clock,
   input  logic                 i_writeEn,
   input  logic [addrBits-1:0]  i_writeAddr,
   input  logic [dataWidth-1:0] i_writeData,
   input  logic [addrBits-1:0]  i_readAddr,
   output logic [dataWidth-1:0] o_readData
);

   logic [dataWidth-1:0] r_mem [2**addrBits];

   // Storage holds no reset; occupancy tracking in the parent decides what is valid.
   always_ff @(posedge i_clock) begin
      if (i_writeEn) begin
         r_mem[i_writeAddr] <= i_writeData;
      end
   end

   assign o_readData = r_mem[i_readAddr];

endmodule

// File: rtl/instruction_fetch_queue.sv
// Decoupling queue between the cacheline parser and the decoders. Words are
// captured with their fetch address, presented first-word-fall-through, and a
// registered stall is raised early enough that words already in flight fit.
module instruction_fetch_queue
   import fetch_pkg::*;
#(
   parameter int depthLog2   = DEPTH_LOG2,
   parameter int skidEntries = SKID_ENTRIES
) (
   input  logic                   clock_i,
   input  logic                   resetn_i,
   input  logic                   flushPipeline_i,
   input  logic                   enable_i,
   input  logic [INSTR_WIDTH-1:0] payload_i,
   input  logic [TAG_SIZE-1:0]    tag_i,
   input  logic [INDEX_SIZE-1:0]  index_i,
   input  logic [OFFSET_SIZE-1:0] offset_i,
   input  logic                   decodeReady_i,
   output logic                   valid_o,
   output logic [INSTR_WIDTH-1:0] instruction_o,
   output logic [ADDR_WIDTH-1:0]  address_o,
   output logic                   fetchUnitStall_o,
   output logic [depthLog2:0]     count_o,
   output logic                   overflow_o
);

   localparam int DEPTH_N = 1 << depthLog2;
   localparam int CNT_W   = depthLog2 + 1;
   localparam logic [CNT_W-1:0]     FULL_COUNT  = CNT_W'(DEPTH_N);
   localparam logic [CNT_W-1:0]     STALL_LEVEL = CNT_W'(DEPTH_N - skidEntries);
   localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
   localparam logic [depthLog2-1:0] PTR_STEP    = depthLog2'(1);

   logic [depthLog2-1:0] r_wrPtr;
   logic [depthLog2-1:0] r_rdPtr;
   logic [CNT_W-1:0]     r_count;
   logic                 r_stall;
   logic                 r_overflow;

   logic                 w_valid;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_drop;
   logic [CNT_W-1:0]     w_nextCount;
   fetchEntry_t          w_writeEntry;
   fetchEntry_t          w_headEntry;

   // A pop needs a valid head; a push at full is only accepted when the head leaves the same cycle.
   assign w_valid = (r_count != '0);
   assign w_full  = (r_count == FULL_COUNT);
   assign w_pop   = w_valid && decodeReady_i;
   assign w_push  = enable_i && (!w_full || w_pop);
   assign w_drop  = enable_i && w_full && !w_pop;

   assign w_writeEntry = '{payload: payload_i, tag: tag_i, index: index_i, offset: offset_i};

   // Occupancy after this edge, ignoring flush which is applied in the register block.
   always_comb begin
      w_nextCount = r_count;
      if (w_push && !w_pop) begin
         w_nextCount = r_count + CNT_ONE;
      end else if (!w_push && w_pop) begin
         w_nextCount = r_count - CNT_ONE;
      end
   end

   // Pointers and occupancy; flush discards everything and ignores the handshakes.
   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (flushPipeline_i) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_STEP;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_STEP;
         end
         r_count <= w_nextCount;
      end
   end

   // Stall goes high once fewer than skidEntries slots remain free; overflow is sticky until flush.
   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_stall    <= 1'b0;
         r_overflow <= 1'b0;
      end else if (flushPipeline_i) begin
         r_stall    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_stall <= (w_nextCount > STALL_LEVEL);
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   fifo_storage_ram #(
      .dataWidth($bits(fetchEntry_t)),
      .addrBits (depthLog2)
   ) storage (
      .i_clock    (clock_i),
      .i_writeEn  (w_push && !flushPipeline_i),
      .i_writeAddr(r_wrPtr),
      .i_writeData(w_writeEntry),
      .i_readAddr (r_rdPtr),
      .o_readData (w_headEntry)
   );

   assign valid_o          = w_valid;
   assign instruction_o    = w_valid ? w_headEntry.payload : '0;
   assign address_o        = w_valid ? entryAddress(w_headEntry) : '0;
   assign fetchUnitStall_o = r_stall;
   assign count_o          = r_count;
   assign overflow_o       = r_overflow;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: directed scenarios plus a
// randomized stream, all compared against a queue-based reference model.
module tb_instruction_fetch_queue;
   import fetch_pkg::*;

   logic                   clock;
   logic                   resetn;
   logic                   flushPipeline;
   logic                   enable;
   logic [INSTR_WIDTH-1:0] payloadIn;
   logic [TAG_SIZE-1:0]    tagIn;
   logic [INDEX_SIZE-1:0]  indexIn;
   logic [OFFSET_SIZE-1:0] offsetIn;
   logic                   decodeReady;
   logic                   valid;
   logic [INSTR_WIDTH-1:0] instruction;
   logic [ADDR_WIDTH-1:0]  address;
   logic                   fetchUnitStall;
   logic [DEPTH_LOG2:0]    count;
   logic                   overflow;

   instruction_fetch_queue dut (
      .clock_i         (clock),
      .resetn_i        (resetn),
      .flushPipeline_i (flushPipeline),
      .enable_i        (enable),
      .payload_i       (payloadIn),
      .tag_i           (tagIn),
      .index_i         (indexIn),
      .offset_i        (offsetIn),
      .decodeReady_i   (decodeReady),
      .valid_o         (valid),
      .instruction_o   (instruction),
      .address_o       (address),
      .fetchUnitStall_o(fetchUnitStall),
      .count_o         (count),
      .overflow_o      (overflow)
   );

   // Free-running clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] payload;
      logic [63:0] addr;
   } refEntry_t;

   localparam int REF_DEPTH = 8;

   refEntry_t refQ[$];
   logic      refOverflow;
   logic      refStall;
   int        checkCount;
   int        passCount;
   int        failCount;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Reference behaviour for one clock edge, from the queue rules.
   task automatic modelEdge(input logic en, input logic ready, input logic flush,
                            input logic [31:0] payload, input logic [63:0] addr);
      logic doPop;
      refEntry_t item;
      if (flush) begin
         refQ.delete();
         refOverflow = 1'b0;
         refStall    = 1'b0;
      end else begin
         doPop = (refQ.size() != 0) && ready;
         if (en && !(refQ.size() < REF_DEPTH || doPop)) refOverflow = 1'b1;
         if (doPop) void'(refQ.pop_front());
         if (en && (refQ.size() < REF_DEPTH)) begin
            item.payload = payload;
            item.addr    = addr;
            refQ.push_back(item);
         end
         refStall = (refQ.size() >= REF_DEPTH - 1);
      end
   endtask

   task automatic compareAll(input string tag);
      logic        expValid;
      logic [31:0] expInstr;
      logic [63:0] expAddr;
      expValid = (refQ.size() != 0);
      expInstr = expValid ? refQ[0].payload : 32'h0;
      expAddr  = expValid ? refQ[0].addr : 64'h0;
      checkOutput({tag, ".valid"}, 64'(valid), 64'(expValid));
      checkOutput({tag, ".instr"}, 64'(instruction), 64'(expInstr));
      checkOutput({tag, ".addr"}, address, expAddr);
      checkOutput({tag, ".count"}, 64'(count), 64'(refQ.size()));
      checkOutput({tag, ".stall"}, 64'(fetchUnitStall), 64'(refStall));
      checkOutput({tag, ".overflow"}, 64'(overflow), 64'(refOverflow));
   endtask

   // Drives one cycle of inputs, advances the model at the edge and checks after it.
   task automatic applyStimulus(input logic en, input logic ready, input logic flush,
                                input logic [31:0] payload, input logic [63:0] addr,
                                input string tag);
      enable        = en;
      decodeReady   = ready;
      flushPipeline = flush;
      payloadIn     = payload;
      tagIn         = addr[63:OFFSET_SIZE+INDEX_SIZE];
      indexIn       = addr[OFFSET_SIZE+INDEX_SIZE-1:OFFSET_SIZE];
      offsetIn      = addr[OFFSET_SIZE-1:0];
      @(posedge clock);
      modelEdge(en, ready, flush, payload, addr);
      #1;
      compareAll(tag);
   endtask

   task automatic resetModel();
      refQ.delete();
      refOverflow = 1'b0;
      refStall    = 1'b0;
   endtask

   initial begin
      logic [63:0] expectAddr;
      logic [63:0] randAddr;
      checkCount    = 0;
      passCount     = 0;
      failCount     = 0;
      resetn        = 1'b1;
      flushPipeline = 1'b0;
      enable        = 1'b0;
      decodeReady   = 1'b0;
      payloadIn     = '0;
      tagIn         = '0;
      indexIn       = '0;
      offsetIn      = '0;
      resetModel();

      // Power-on reset, checked before any clock edge completes.
      #2 resetn = 1'b0;
      #1;
      compareAll("reset");
      repeat (2) @(posedge clock);
      @(negedge clock) resetn = 1'b1;

      // Single push into an empty queue shows up one cycle later.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h7C0802A6, {51'd1, 8'd2, 5'd4}, "emptyPush");
      expectAddr = {51'd1, 8'd2, 5'd4};
      checkOutput("emptyPush.instrConst", 64'(instruction), 64'h7C0802A6);
      checkOutput("emptyPush.addrConst", address, expectAddr);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 64'h0, "emptyPop");

      // Fill to depth with the decoder stalled; stall rises at 7 entries.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'hA000_0000 + i, 64'h1000 + 4 * i, "fill");
         checkOutput("fill.countConst", 64'(count), 64'(i + 1));
         checkOutput("fill.stallConst", 64'(fetchUnitStall), 64'((i + 1) >= 7));
      end

      // Drain in push order.
      for (int k = 0; k < 8; k++) begin
         checkOutput("drain.addrConst", address, 64'h1000 + 4 * k);
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 64'h0, "drain");
      end
      checkOutput("drain.validFalls", 64'(valid), 64'd0);

      // Refill, then push and pop together at full, then push at full without pop.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'hB000_0000 + i, 64'h2000 + 4 * i, "refill");
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 32'hB000_0008, 64'h2020, "fullBoth");
      checkOutput("fullBoth.countConst", 64'(count), 64'd8);
      checkOutput("fullBoth.overflowConst", 64'(overflow), 64'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 64'h3000, "fullDrop");
      checkOutput("fullDrop.overflowConst", 64'(overflow), 64'd1);
      checkOutput("fullDrop.countConst", 64'(count), 64'd8);

      // Leave 4 entries, then flush while a push is offered.
      repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 64'h0, "toFour");
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hFEED_0001, 64'h4000, "flush");
      checkOutput("flush.countConst", 64'(count), 64'd0);
      checkOutput("flush.overflowConst", 64'(overflow), 64'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, "afterFlush");

      // Streaming push/pop across the pointer wrap with 3 entries resident.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'hC000_0000 + i, 64'h5000 + 4 * i, "prime");
      end
      for (int i = 3; i < 23; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'hC000_0000 + i, 64'h5000 + 4 * i, "wrap");
         checkOutput("wrap.countConst", 64'(count), 64'd3);
      end

      // Randomized traffic: a fill-biased phase, then a drain-biased phase.
      for (int c = 0; c < 400; c++) begin
         randAddr = {$urandom(), $urandom()};
         if (c < 200) begin
            applyStimulus($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 35,
                          $urandom_range(0, 99) < 3, $urandom(), randAddr, "random");
         end else begin
            applyStimulus($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 70,
                          $urandom_range(0, 99) < 3, $urandom(), randAddr, "random");
         end
      end

      // Asynchronous reset with 5 entries queued, checked mid-cycle.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 64'h0, "preReset");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'hE000_0000 + i, 64'h6000 + 4 * i, "queue5");
      end
      enable = 1'b0;
      #2 resetn = 1'b0;
      #1;
      resetModel();
      compareAll("asyncReset5");
      @(negedge clock) resetn = 1'b1;

      // Asynchronous reset with the queue full, stalled and overflowed.
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'hF000_0000 + i, 64'h7000 + 4 * i, "queueFull");
      end
      enable = 1'b0;
      #2 resetn = 1'b0;
      #1;
      resetModel();
      compareAll("asyncResetFull");
      @(negedge clock) resetn = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 64'h0, "postReset");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
